// File: rtl/raizing_input_cond_pkg.sv
// rtl/raizing_input_cond_pkg.sv - shared constants, coin-shaper states and SOCD helper
package raizing_input_pkg;

  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    PULSE = ST_PULSE,
    GAP   = ST_GAP
  } coin_state_e;

  // Opposing directions cancel each other; buttons pass untouched.
  function automatic logic [9:0] socd_clean(input logic [9:0] j);
    logic [9:0] r;
    r = j;
    if (j[JOY_UP] && j[JOY_DOWN]) begin
      r[JOY_UP]   = 1'b0;
      r[JOY_DOWN] = 1'b0;
    end
    if (j[JOY_LEFT] && j[JOY_RIGHT]) begin
      r[JOY_LEFT]  = 1'b0;
      r[JOY_RIGHT] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/raizing_input_cond_if.sv
// rtl/raizing_input_cond_if.sv - raw control inputs and conditioned outputs of the input block
interface raizing_input_cond_if;
  logic       LVBL;
  logic [9:0] JOYSTICK1_RAW;
  logic [9:0] JOYSTICK2_RAW;
  logic [3:0] START_RAW;
  logic [3:0] COIN_RAW;
  logic       SERVICE_RAW;
  logic [9:0] JOYSTICK1;
  logic [9:0] JOYSTICK2;
  logic [3:0] START_BUTTON;
  logic [3:0] COIN_INPUT;
  logic       SERVICE;

  modport master (
    output LVBL, JOYSTICK1_RAW, JOYSTICK2_RAW, START_RAW, COIN_RAW, SERVICE_RAW,
    input  JOYSTICK1, JOYSTICK2, START_BUTTON, COIN_INPUT, SERVICE
  );

  modport slave (
    input  LVBL, JOYSTICK1_RAW, JOYSTICK2_RAW, START_RAW, COIN_RAW, SERVICE_RAW,
    output JOYSTICK1, JOYSTICK2, START_BUTTON, COIN_INPUT, SERVICE
  );
endinterface

// File: rtl/raizing_input_cond_coin_shaper.sv
// rtl/raizing_input_cond_coin_shaper.sv - frame-locked coin pulse shaper with a 3-deep press queue
module raizing_coin_shaper
  import raizing_input_pkg::*;
#(
  parameter int COIN_FRAMES = 3,
  parameter int COIN_GAP    = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic strobe_i,
  input  logic coin_i,
  output logic coin_o
);
  coin_state_e state_q, state_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic [1:0]  pend_q, pend_d;
  logic        coin_q, coin_d;
  logic        prev_q;
  logic        rise, take;

  assign rise   = coin_i & ~prev_q;
  assign coin_o = coin_q;

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    coin_d  = coin_q;
    take    = 1'b0;
    case (state_q)
      // A fresh edge starts the pulse directly so COIN follows one cycle later.
      IDLE: if (pend_q != 2'd0 || rise) begin
        take    = 1'b1;
        state_d = PULSE;
        fcnt_d  = 4'd0;
        coin_d  = 1'b1;
      end
      PULSE: if (strobe_i) begin
        if (fcnt_q == 4'(COIN_FRAMES - 1)) begin
          state_d = GAP;
          fcnt_d  = 4'd0;
          coin_d  = 1'b0;
        end else begin
          fcnt_d = fcnt_q + 4'd1;
        end
      end
      GAP: if (strobe_i) begin
        if (fcnt_q == 4'(COIN_GAP - 1)) begin
          state_d = IDLE;
          fcnt_d  = 4'd0;
        end else begin
          fcnt_d = fcnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    case ({rise, take})
      2'b10:   pend_d = (pend_q == 2'd3) ? 2'd3 : pend_q + 2'd1;
      2'b01:   pend_d = pend_q - 2'd1;
      default: pend_d = pend_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      fcnt_q  <= 4'd0;
      pend_q  <= 2'd0;
      coin_q  <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pend_q  <= pend_d;
      coin_q  <= coin_d;
      prev_q  <= coin_i;
    end
  end
endmodule

// File: rtl/raizing_input_cond.sv
// rtl/raizing_input_cond.sv - synchronize, debounce and shape the Raizing player controls
// Define RAIZING_SOCD_EN to clear opposing joystick directions.
module raizing_input_cond
  import raizing_input_pkg::*;
#(
  parameter int DEB_DIV     = 48000,
  parameter int DEB_LEN     = 3,
  parameter int COIN_FRAMES = 3,
  parameter int COIN_GAP    = 3
) (
  input logic                 CLK,
  input logic                 RESET_N,
  raizing_input_cond_if.slave io
);
  localparam int NB = 29;
  localparam int DW = $clog2(DEB_DIV);

  logic [NB-1:0]              raw, sync1_q, sync2_q, deb_q, deb_d;
  logic [NB-1:0][DEB_LEN-1:0] hist_q, hist_d;
  logic [DW-1:0]              div_q, div_d;
  logic                       tick, lvbl_q, strobe;
  logic [9:0]                 joy1, joy2;
  logic [3:0]                 coin_out;

  // Bit map: joy1 [9:0], joy2 [19:10], start [23:20], coin [27:24], service [28].
  assign raw    = {io.SERVICE_RAW, io.COIN_RAW, io.START_RAW, io.JOYSTICK2_RAW, io.JOYSTICK1_RAW};
  assign tick   = (div_q == DW'(DEB_DIV - 1));
  assign div_d  = tick ? '0 : div_q + DW'(1);
  assign strobe = lvbl_q & ~io.LVBL;

  always_comb begin
    hist_d = hist_q;
    deb_d  = deb_q;
    if (tick) begin
      for (int b = 0; b < NB; b++) begin
        hist_d[b] = {hist_q[b][DEB_LEN-2:0], sync2_q[b]};
        if (hist_d[b] == {DEB_LEN{sync2_q[b]}}) deb_d[b] = sync2_q[b];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
      deb_q   <= '0;
      div_q   <= '0;
      lvbl_q  <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      hist_q  <= hist_d;
      deb_q   <= deb_d;
      div_q   <= div_d;
      lvbl_q  <= io.LVBL;
    end
  end

`ifdef RAIZING_SOCD_EN
  assign joy1 = socd_clean(deb_q[9:0]);
  assign joy2 = socd_clean(deb_q[19:10]);
`else
  assign joy1 = deb_q[9:0];
  assign joy2 = deb_q[19:10];
`endif

  for (genvar c = 0; c < 4; c++) begin : g_coin
    raizing_coin_shaper #(
      .COIN_FRAMES(COIN_FRAMES),
      .COIN_GAP   (COIN_GAP)
    ) u_shaper (
      .clk_i   (CLK),
      .rst_ni  (RESET_N),
      .strobe_i(strobe),
      .coin_i  (deb_q[24+c]),
      .coin_o  (coin_out[c])
    );
  end

  assign io.JOYSTICK1    = joy1;
  assign io.JOYSTICK2    = joy2;
  assign io.START_BUTTON = deb_q[23:20];
  assign io.COIN_INPUT   = coin_out;
  assign io.SERVICE      = deb_q[28];
endmodule

// File: tb/tb_raizing_input_cond.sv
// tb/tb_raizing_input_cond.sv - directed bench for raizing_input_cond
module tb_raizing_input_cond;
  localparam int DEB_DIV = 4, DEB_LEN = 3, COIN_FRAMES = 2, COIN_GAP = 2;
`ifdef RAIZING_SOCD_EN
  localparam logic [9:0] JOY2_EXP = 10'b0000010000;
`else
  localparam logic [9:0] JOY2_EXP = 10'b0000010011;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   ncmp = 0;
  int   nfail = 0;
  int   pulse_cnt[4], width_bad[4], gap_bad[4], last_width[4], hi_str[4], lo_str[4];
  logic [3:0] coin_prev;
  logic [28:0] outs;

  raizing_input_cond_if io ();

  raizing_input_cond #(
    .DEB_DIV(DEB_DIV), .DEB_LEN(DEB_LEN), .COIN_FRAMES(COIN_FRAMES), .COIN_GAP(COIN_GAP)
  ) dut (
    .CLK    (clk),
    .RESET_N(rst_n),
    .io     (io)
  );

  always #5 clk = ~clk;

  assign outs = {io.SERVICE, io.COIN_INPUT, io.START_BUTTON, io.JOYSTICK2, io.JOYSTICK1};

  // Frame timing: LVBL high 40 cycles, low 10 cycles.
  initial begin
    io.LVBL = 1'b1;
    forever begin
      repeat (40) @(posedge clk);
      #1 io.LVBL = 1'b0;
      repeat (10) @(posedge clk);
      #1 io.LVBL = 1'b1;
    end
  end

  // Coin pulse monitor: counts frame strobes seen while each COIN is high / low.
  initial begin
    logic lv_prev, fall, c;
    lv_prev   = 1'b1;
    coin_prev = '0;
    for (int s = 0; s < 4; s++) begin
      pulse_cnt[s] = 0; width_bad[s] = 0; gap_bad[s] = 0;
      last_width[s] = 0; hi_str[s] = 0; lo_str[s] = 99;
    end
    forever begin
      @(negedge clk);
      fall    = lv_prev & ~io.LVBL;
      lv_prev = io.LVBL;
      for (int s = 0; s < 4; s++) begin
        c = io.COIN_INPUT[s];
        if (c && !coin_prev[s]) begin
          pulse_cnt[s]++;
          if (pulse_cnt[s] > 1 && lo_str[s] < COIN_GAP) gap_bad[s]++;
          hi_str[s] = 0;
        end
        if (!c && coin_prev[s]) begin
          last_width[s] = hi_str[s];
          if (rst_n && hi_str[s] != COIN_FRAMES) width_bad[s]++;
          lo_str[s] = 0;
        end
        if (fall) begin
          if (c) hi_str[s]++;
          else   lo_str[s]++;
        end
        coin_prev[s] = c;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    rst_n            = 1'b0;
    io.JOYSTICK1_RAW = '0;
    io.JOYSTICK2_RAW = '0;
    io.START_RAW     = '0;
    io.COIN_RAW      = '0;
    io.SERVICE_RAW   = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step(1);
      check("reset_hold_outs", 32'(outs), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 101; i++) begin
      step(1);
      check("post_reset_outs", 32'(outs), 32'd0);
    end

    // Bounce: toggle every 3 cycles for 40 cycles, then hold high.
    for (int r = 0; r < 40; r++) begin
      io.JOYSTICK1_RAW[4] = ((r / 3) % 2) == 1;
      step(1);
      check("bounce_quiet", 32'(io.JOYSTICK1[4]), 32'd0);
    end
    io.JOYSTICK1_RAW[4] = 1'b1;
    n = 0;
    while (io.JOYSTICK1[4] !== 1'b1 && n < 20) begin
      step(1);
      n++;
    end
    ncmp++;
    assert (n >= 11 && n <= 15) else begin
      nfail++;
      $error("FAIL bounce_latency observed=%0d expected=11..15", n);
    end

    // Single coin held for 100 cycles.
    io.COIN_RAW[0] = 1'b1;
    step(100);
    io.COIN_RAW[0] = 1'b0;
    step(300);
    check("coin0_pulses", 32'(pulse_cnt[0]), 32'd1);
    check("coin0_width", 32'(last_width[0]), 32'd2);
    check("coin0_width_bad", 32'(width_bad[0]), 32'd0);
    check("coin0_low", 32'(io.COIN_INPUT[0]), 32'd0);

    // Queue: five presses right after a frame strobe.
    n = 0;
    while (io.LVBL !== 1'b1 && n < 60) begin step(1); n++; end
    while (io.LVBL !== 1'b0 && n < 120) begin step(1); n++; end
    check("lvbl_align_timeout", 32'(n < 120), 32'd1);
    for (int k = 0; k < 5; k++) begin
      io.COIN_RAW[1] = 1'b1;
      step(16);
      io.COIN_RAW[1] = 1'b0;
      step(16);
    end
    n = 0;
    while (pulse_cnt[1] < 4 && n < 1500) begin step(1); n++; end
    check("coin1_wait_timeout", 32'(n < 1500), 32'd1);
    step(400);
    check("coin1_pulses", 32'(pulse_cnt[1]), 32'd4);
    check("coin1_width_bad", 32'(width_bad[1]), 32'd0);
    check("coin1_gap_bad", 32'(gap_bad[1]), 32'd0);

    // Direction cleaning, starts and service.
    io.JOYSTICK2_RAW = 10'b0000010011;
    io.START_RAW     = 4'b1010;
    io.SERVICE_RAW   = 1'b1;
    step(25);
    check("joy2_socd", 32'(io.JOYSTICK2), 32'(JOY2_EXP));
    check("start_btn", 32'(io.START_BUTTON), 32'hA);
    check("service", 32'(io.SERVICE), 32'd1);
    check("joy1_hold", 32'(io.JOYSTICK1), 32'h010);

    // Reset in the middle of a coin pulse with one press queued.
    io.COIN_RAW[2] = 1'b1;
    step(16);
    io.COIN_RAW[2] = 1'b0;
    n = 0;
    while (io.COIN_INPUT[2] !== 1'b1 && n < 40) begin step(1); n++; end
    check("coin2_rise_timeout", 32'(n < 40), 32'd1);
    io.COIN_RAW[2] = 1'b1;
    step(16);
    io.COIN_RAW[2] = 1'b0;
    step(4);
    check("coin2_mid_pulse", 32'(io.COIN_INPUT[2]), 32'd1);
    check("coin2_pulses_pre", 32'(pulse_cnt[2]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", 32'(outs), 32'd0);
    step(3);
    rst_n = 1'b1;
    step(300);
    check("coin2_no_replay", 32'(pulse_cnt[2]), 32'd1);
    check("coin2_low", 32'(io.COIN_INPUT[2]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
